// File: rtl/vending_machine_pkg.sv
// Vending machine shared types: state codes, product prices, coin set.
// Helper functions map a product select to its price and screen coins.
package vending_machine_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        SELECT   = 3'b001,
        COLLECT  = 3'b010,
        DISPENSE = 3'b011,
        REFUND   = 3'b100
    } state_t;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_P1   = 2'b01;
    localparam logic [1:0] CH_P2   = 2'b10;
    localparam logic [1:0] CH_P3   = 2'b11;

    localparam logic [4:0] PRICE_P1 = 5'd2;
    localparam logic [4:0] PRICE_P2 = 5'd5;
    localparam logic [4:0] PRICE_P3 = 5'd10;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_2  = 4'd2;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    function automatic logic coin_ok(input logic [3:0] m);
        return (m == COIN_1) || (m == COIN_2) ||
               (m == COIN_5) || (m == COIN_10);
    endfunction

    function automatic logic [4:0] price_of(input logic [1:0] c);
        logic [4:0] p;
        p = 5'd0;
        unique case (c)
            CH_P1:   p = PRICE_P1;
            CH_P2:   p = PRICE_P2;
            CH_P3:   p = PRICE_P3;
            default: p = 5'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vending_machine_if.sv
// Customer-side bundle: coin and product select in, state and
// dispense/change results out.
interface vending_machine_if;
    import vending_machine_pkg::*;

    logic [3:0] money;
    logic [1:0] choice;
    logic [2:0] states;
    logic       delivery;
    logic [3:0] change;

    modport master (
        output money, choice,
        input  states, delivery, change
    );

    modport slave (
        input  money, choice,
        output states, delivery, change
    );

endinterface

// File: rtl/vending_machine.sv
// Coin-operated vending FSM: latch product, collect coins, then
// dispense with change or refund on cancel.
module vending_machine
    import vending_machine_pkg::*;
(
    input  logic       clk,
    input  logic [3:0] money,
    input  logic       reset,
    output logic [2:0] states,
    input  logic [1:0] choice,
    output logic       delivery,
    output logic [3:0] change
);

    state_t     state_q, state_d;
    logic [4:0] credit_q, credit_d;
    logic [4:0] price_q, price_d;
    logic       deliv_d;
    logic [3:0] change_d;
    logic [4:0] coin;
    logic [4:0] sum;

    always_comb begin
        coin     = coin_ok(money) ? {1'b0, money} : 5'd0;
        sum      = credit_q + coin;
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        deliv_d  = 1'b0;
        change_d = 4'd0;
        case (state_q)
            IDLE: begin
                credit_d = 5'd0;
                if (choice != CH_NONE) begin
                    price_d = price_of(choice);
                    state_d = SELECT;
                end
            end
            SELECT, COLLECT: begin
                // Reaching the price wins over a same-cycle cancel.
                if (sum >= price_q) begin
                    state_d  = DISPENSE;
                    deliv_d  = 1'b1;
                    change_d = 4'(sum - price_q);
                    credit_d = 5'd0;
                end else if (choice == CH_NONE) begin
                    credit_d = 5'd0;
                    if (state_q == SELECT && coin == 5'd0) begin
                        state_d = IDLE;
                        price_d = 5'd0;
                    end else begin
                        state_d  = REFUND;
                        change_d = sum[3:0];
                    end
                end else if (coin != 5'd0) begin
                    state_d  = COLLECT;
                    credit_d = sum;
                end
            end
            DISPENSE, REFUND: begin
                state_d  = IDLE;
                credit_d = 5'd0;
                price_d  = 5'd0;
            end
            default: begin
                state_d  = IDLE;
                credit_d = 5'd0;
                price_d  = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= 5'd0;
            price_q  <= 5'd0;
            delivery <= 1'b0;
            change   <= 4'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            delivery <= deliv_d;
            change   <= change_d;
        end
    end

    assign states = state_q;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench: each stimulus step queues the expected outputs for
// the following cycle; a negedge monitor pops and compares them.
module tb_vending_machine;
    import vending_machine_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       del;
        logic [3:0] chg;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];

    vending_machine_if vif ();

    vending_machine dut (
        .clk      (clk),
        .money    (vif.money),
        .reset    (reset),
        .states   (vif.states),
        .choice   (vif.choice),
        .delivery (vif.delivery),
        .change   (vif.change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t s;
            s = sb.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL %s: expectation for cycle %0d never checked",
                     s.name, s.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            tests = tests + 1;
            if (vif.states !== e.st || vif.delivery !== e.del ||
                vif.change !== e.chg) begin
                fails = fails + 1;
                $display("FAIL %s: got st=%b del=%b chg=%0d, want st=%b del=%b chg=%0d",
                         e.name, vif.states, vif.delivery, vif.change,
                         e.st, e.del, e.chg);
            end
        end
    end

    task automatic step(input string nm, input logic r,
                        input logic [1:0] c, input logic [3:0] m,
                        input state_t es, input logic ed,
                        input logic [3:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = r;
        vif.choice = c;
        vif.money  = m;
        e.cyc  = cyc + 1;
        e.st   = es;
        e.del  = ed;
        e.chg  = ec;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        vif.choice = 2'b00;
        vif.money  = 4'd0;

        step("reset",       1'b0, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);
        step("r29_sel",     1'b1, 2'b10, 4'd0,  SELECT,   1'b0, 4'd0);
        step("r29_disp",    1'b1, 2'b10, 4'd10, DISPENSE, 1'b1, 4'd5);
        step("r29_idle",    1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("r30_sel",     1'b1, 2'b01, 4'd0,  SELECT,   1'b0, 4'd0);
        step("r30_coll",    1'b1, 2'b01, 4'd1,  COLLECT,  1'b0, 4'd0);
        step("r30_disp",    1'b1, 2'b01, 4'd1,  DISPENSE, 1'b1, 4'd0);
        step("r30_idle",    1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("r31_sel",     1'b1, 2'b11, 4'd0,  SELECT,   1'b0, 4'd0);
        step("r31_c5",      1'b1, 2'b11, 4'd5,  COLLECT,  1'b0, 4'd0);
        step("r31_c2",      1'b1, 2'b11, 4'd2,  COLLECT,  1'b0, 4'd0);
        step("r31_refund",  1'b1, 2'b00, 4'd0,  REFUND,   1'b0, 4'd7);
        step("r31_idle",    1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("r32_sel",     1'b1, 2'b10, 4'd0,  SELECT,   1'b0, 4'd0);
        step("r32_bad",     1'b1, 2'b10, 4'd3,  SELECT,   1'b0, 4'd0);
        step("r32_disp",    1'b1, 2'b10, 4'd5,  DISPENSE, 1'b1, 4'd0);
        step("r32_idle",    1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("r33_sel",     1'b1, 2'b11, 4'd0,  SELECT,   1'b0, 4'd0);
        step("r33_c5",      1'b1, 2'b11, 4'd5,  COLLECT,  1'b0, 4'd0);
        step("r33_rst",     1'b0, 2'b11, 4'd5,  IDLE,     1'b0, 4'd0);
        step("r33_after",   1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("r34_idle10",  1'b1, 2'b00, 4'd10, IDLE,     1'b0, 4'd0);

        step("cxl_sel",     1'b1, 2'b01, 4'd0,  SELECT,   1'b0, 4'd0);
        step("cxl_coll",    1'b1, 2'b01, 4'd1,  COLLECT,  1'b0, 4'd0);
        step("cxl_disp",    1'b1, 2'b00, 4'd2,  DISPENSE, 1'b1, 4'd1);
        step("cxl_idle",    1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("relatch_sel", 1'b1, 2'b10, 4'd0,  SELECT,   1'b0, 4'd0);
        step("relatch_dsp", 1'b1, 2'b11, 4'd5,  DISPENSE, 1'b1, 4'd0);
        step("relatch_idl", 1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("sel_cancel0", 1'b1, 2'b01, 4'd0,  SELECT,   1'b0, 4'd0);
        step("sel_cancel1", 1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("refc_sel",    1'b1, 2'b11, 4'd0,  SELECT,   1'b0, 4'd0);
        step("refc_c2",     1'b1, 2'b11, 4'd2,  COLLECT,  1'b0, 4'd0);
        step("refc_ref",    1'b1, 2'b00, 4'd1,  REFUND,   1'b0, 4'd3);
        step("refc_idle",   1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        step("max_sel",     1'b1, 2'b01, 4'd0,  SELECT,   1'b0, 4'd0);
        step("max_c1",      1'b1, 2'b01, 4'd1,  COLLECT,  1'b0, 4'd0);
        step("max_c10",     1'b1, 2'b01, 4'd10, DISPENSE, 1'b1, 4'd9);
        step("max_idle",    1'b1, 2'b00, 4'd0,  IDLE,     1'b0, 4'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
